// File: rtl/unidad_salto.sv
// ============================================================================
// unidad_salto : ID-stage branch resolution and operand-hazard stall control
// Revision     : 1.0
// ============================================================================
`default_nettype none

module unidad_salto (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch_id,
  input  logic        bne_id,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        igual,
  input  logic        regwrite_ex,
  input  logic        memread_ex,
  input  logic [4:0]  rd_ex,
  input  logic        memread_mem,
  input  logic [4:0]  rd_mem,
  input  logic [31:0] target_id,
  output logic        stall,
  output logic        flush_if_id,
  output logic        pc_src,
  output logic [31:0] pc_branch,
  output logic [15:0] branch_count,
  output logic [15:0] taken_count,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RES  = 2'd2
  } state_t;

  localparam logic [15:0] C_SAT = 16'hFFFF;

  state_t      state_q, state_d;
  logic [15:0] branch_count_q, taken_count_q, stall_cycles_q;
  logic        w_dep_ex, w_dep_mem, w_need2, w_need1, w_taken, w_resolve;

  always_comb begin
    w_dep_ex  = (rd_ex  != 5'd0) && ((rd_ex  == rs_id) || (rd_ex  == rt_id));
    w_dep_mem = (rd_mem != 5'd0) && ((rd_mem == rs_id) || (rd_mem == rt_id));
    w_need2   = memread_ex && w_dep_ex;
    w_need1   = !w_need2 && ((regwrite_ex && w_dep_ex) || (memread_mem && w_dep_mem));
    w_taken   = igual ^ bne_id;

    state_d   = state_q;
    stall     = 1'b0;
    w_resolve = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (branch_id) begin
          if (w_need2) begin
            stall   = 1'b1;
            state_d = S_WAIT;
          end else if (w_need1) begin
            stall   = 1'b1;
            state_d = S_RES;
          end else begin
            w_resolve = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (branch_id) begin
          stall   = 1'b1;
          state_d = S_RES;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RES: begin
        w_resolve = branch_id;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset suppresses resolution, but a stall already committed by WAIT still shows.
    if (!reset_n) begin
      w_resolve = 1'b0;
      state_d   = S_IDLE;
      if (state_q != S_WAIT) stall = 1'b0;
    end

    pc_src      = w_resolve && w_taken;
    flush_if_id = w_resolve && w_taken;
    pc_branch   = target_id;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      branch_count_q <= 16'd0;
      taken_count_q  <= 16'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (w_resolve && (branch_count_q != C_SAT))
        branch_count_q <= branch_count_q + 16'd1;
      if (w_resolve && w_taken && (taken_count_q != C_SAT))
        taken_count_q <= taken_count_q + 16'd1;
      if (stall && (stall_cycles_q != C_SAT))
        stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;
  assign stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_unidad_salto.sv
// ============================================================================
// tb_unidad_salto : randomized and directed bench for unidad_salto
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_unidad_salto;

  logic        clk = 1'b0;
  logic        reset_n, branch_id, bne_id, igual;
  logic [4:0]  rs_id, rt_id, rd_ex, rd_mem;
  logic        regwrite_ex, memread_ex, memread_mem;
  logic [31:0] target_id;
  logic        stall, flush_if_id, pc_src;
  logic [31:0] pc_branch;
  logic [15:0] branch_count, taken_count, stall_cycles;

  int checks   = 0;
  int failures = 0;

  // Reference: a pending branch waiting out m_rem more stall cycles before resolving.
  bit m_pend = 0;
  int m_rem  = 0;
  int m_bc = 0, m_tc = 0, m_sc = 0;

  unidad_salto dut (
    .clk(clk), .reset_n(reset_n), .branch_id(branch_id), .bne_id(bne_id),
    .rs_id(rs_id), .rt_id(rt_id), .igual(igual), .regwrite_ex(regwrite_ex),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .memread_mem(memread_mem),
    .rd_mem(rd_mem), .target_id(target_id), .stall(stall),
    .flush_if_id(flush_if_id), .pc_src(pc_src), .pc_branch(pc_branch),
    .branch_count(branch_count), .taken_count(taken_count),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic clear_inputs();
    branch_id = 0; bne_id = 0; igual = 0; rs_id = 0; rt_id = 0;
    regwrite_ex = 0; memread_ex = 0; rd_ex = 0; memread_mem = 0; rd_mem = 0;
    target_id = 32'h0;
  endtask

  // One clock: check combinational outputs and counters at negedge, advance model at posedge.
  task automatic step();
    int  n;
    bit  dex, dmem, e_stall, res, tk, nx_pend;
    int  nx_rem;
    @(negedge clk);
    dex  = (rd_ex  != 0) && (rd_ex  == rs_id || rd_ex  == rt_id);
    dmem = (rd_mem != 0) && (rd_mem == rs_id || rd_mem == rt_id);
    if (memread_ex && dex) n = 2;
    else if ((regwrite_ex && dex) || (memread_mem && dmem)) n = 1;
    else n = 0;
    tk = igual ^ bne_id;
    e_stall = 0; res = 0; nx_pend = 0; nx_rem = 0;
    if (!m_pend) begin
      if (branch_id) begin
        if (n == 0) res = 1;
        else begin e_stall = 1; nx_pend = 1; nx_rem = n - 1; end
      end
    end else if (branch_id) begin
      if (m_rem > 0) begin e_stall = 1; nx_pend = 1; nx_rem = m_rem - 1; end
      else res = 1;
    end
    if (!reset_n) begin
      res = 0; nx_pend = 0;
      if (!(m_pend && m_rem > 0)) e_stall = 0;
    end
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("pc_src", {31'd0, pc_src}, {31'd0, res && tk});
    chk("flush", {31'd0, flush_if_id}, {31'd0, res && tk});
    chk("pc_branch", pc_branch, target_id);
    chk("branch_count", {16'd0, branch_count}, m_bc);
    chk("taken_count", {16'd0, taken_count}, m_tc);
    chk("stall_cycles", {16'd0, stall_cycles}, m_sc);
    @(posedge clk);
    if (!reset_n) begin
      m_bc = 0; m_tc = 0; m_sc = 0;
    end else begin
      if (res) m_bc = sat(m_bc);
      if (res && tk) m_tc = sat(m_tc);
      if (e_stall) m_sc = sat(m_sc);
    end
    m_pend = nx_pend;
    m_rem  = nx_rem;
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    #1;

    // Reset held with a branch present
    branch_id = 1; igual = 1;
    step(); step();
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pc_src", {31'd0, pc_src}, 32'd0);
    chk("rst_bc", {16'd0, branch_count}, 32'd0);
    chk("rst_sc", {16'd0, stall_cycles}, 32'd0);

    // beq taken, no hazard
    do_reset();
    branch_id = 1; bne_id = 0; igual = 1; target_id = 32'h00400020;
    #1;
    chk("beq_pc_src", {31'd0, pc_src}, 32'd1);
    chk("beq_flush", {31'd0, flush_if_id}, 32'd1);
    chk("beq_target", pc_branch, 32'h00400020);
    step();
    clear_inputs(); #1;
    chk("beq_bc", {16'd0, branch_count}, 32'd1);
    chk("beq_tc", {16'd0, taken_count}, 32'd1);

    // bne behind an ALU producer in EX
    do_reset();
    branch_id = 1; bne_id = 1; igual = 1; rs_id = 8; regwrite_ex = 1; rd_ex = 8;
    #1; chk("alu_stall", {31'd0, stall}, 32'd1);
    step();
    #1;
    chk("alu_res_stall", {31'd0, stall}, 32'd0);
    chk("alu_res_pc_src", {31'd0, pc_src}, 32'd0);
    chk("alu_res_flush", {31'd0, flush_if_id}, 32'd0);
    step();
    clear_inputs(); #1;
    chk("alu_sc", {16'd0, stall_cycles}, 32'd1);
    chk("alu_tc", {16'd0, taken_count}, 32'd0);
    chk("alu_bc", {16'd0, branch_count}, 32'd1);

    // beq behind a load in EX
    do_reset();
    branch_id = 1; igual = 1; rt_id = 9; memread_ex = 1; rd_ex = 9;
    #1; chk("ld_stall0", {31'd0, stall}, 32'd1);
    step();
    #1; chk("ld_stall1", {31'd0, stall}, 32'd1);
    step();
    #1;
    chk("ld_res_pc_src", {31'd0, pc_src}, 32'd1);
    chk("ld_res_stall", {31'd0, stall}, 32'd0);
    step();
    clear_inputs(); #1;
    chk("ld_sc", {16'd0, stall_cycles}, 32'd2);

    // Writer of r0 is not a hazard
    do_reset();
    branch_id = 1; igual = 1; regwrite_ex = 1; rd_ex = 0;
    #1;
    chk("r0_stall", {31'd0, stall}, 32'd0);
    chk("r0_pc_src", {31'd0, pc_src}, 32'd1);
    step();

    // Reset arriving while in WAIT
    clear_inputs();
    branch_id = 1; rs_id = 3; memread_ex = 1; rd_ex = 3;
    step();
    reset_n = 0;
    #1; chk("wrst_stall", {31'd0, stall}, 32'd1);
    step();
    reset_n = 1; clear_inputs(); #1;
    chk("wrst_sc", {16'd0, stall_cycles}, 32'd0);
    chk("wrst_bc", {16'd0, branch_count}, 32'd0);
    chk("wrst_stall_after", {31'd0, stall}, 32'd0);

    // Randomized traffic with a narrow register range so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      reset_n     = ($urandom_range(0, 59) != 0);
      branch_id   = ($urandom_range(0, 9) < 8);
      bne_id      = $urandom_range(0, 1);
      igual       = $urandom_range(0, 1);
      rs_id       = 5'($urandom_range(0, 3));
      rt_id       = 5'($urandom_range(0, 3));
      rd_ex       = 5'($urandom_range(0, 3));
      rd_mem      = 5'($urandom_range(0, 3));
      regwrite_ex = $urandom_range(0, 1);
      memread_ex  = ($urandom_range(0, 3) == 0);
      memread_mem = ($urandom_range(0, 2) == 0);
      target_id   = $urandom;
      step();
    end

    // Counter saturation
    do_reset();
    branch_id = 1; igual = 1; target_id = 32'h00001000;
    for (int i = 0; i < 65540; i++) step();
    clear_inputs(); #1;
    chk("sat_bc", {16'd0, branch_count}, 32'h0000FFFF);
    chk("sat_tc", {16'd0, taken_count}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
